// File: rtl/tia_audio_pkg.sv
// Shared constants for the TIA audio channel: AUDC modes, LFSR geometry and counter limits.
package tia_audio_pkg;

  localparam logic [3:0] AUDC_ONE_A    = 4'd0;
  localparam logic [3:0] AUDC_P4       = 4'd1;
  localparam logic [3:0] AUDC_P5_P4    = 4'd2;
  localparam logic [3:0] AUDC_P5       = 4'd3;
  localparam logic [3:0] AUDC_DIV2_A   = 4'd4;
  localparam logic [3:0] AUDC_DIV2_B   = 4'd5;
  localparam logic [3:0] AUDC_DIV31_A  = 4'd6;
  localparam logic [3:0] AUDC_P5_A     = 4'd7;
  localparam logic [3:0] AUDC_P9       = 4'd8;
  localparam logic [3:0] AUDC_P5_B     = 4'd9;
  localparam logic [3:0] AUDC_DIV31_B  = 4'd10;
  localparam logic [3:0] AUDC_ONE_B    = 4'd11;
  localparam logic [3:0] AUDC_DIV6_A   = 4'd12;
  localparam logic [3:0] AUDC_DIV6_B   = 4'd13;
  localparam logic [3:0] AUDC_DIV93    = 4'd14;
  localparam logic [3:0] AUDC_P5_DIV6  = 4'd15;

  localparam int P4_W   = 4;
  localparam int P4_TAP = 2;
  localparam int P5_W   = 5;
  localparam int P5_TAP = 2;
  localparam int P9_W   = 9;
  localparam int P9_TAP = 4;

  localparam logic [P4_W-1:0] P4_SEED = 4'hF;
  localparam logic [P5_W-1:0] P5_SEED = 5'h1F;
  localparam logic [P9_W-1:0] P9_SEED = 9'h1FF;

  localparam logic [4:0] C31_DUTY = 5'd18;
  localparam logic [2:0] C6_DUTY  = 3'd3;
  localparam logic [1:0] C3_LAST  = 2'd2;
  localparam logic [2:0] C6_LAST  = 3'd5;
  localparam logic [4:0] C31_LAST = 5'd30;

  // One advance request per generator, produced by the mode mux each cycle.
  typedef struct packed {
    logic p4;
    logic p5;
    logic p9;
    logic t2;
    logic c3;
    logic c6;
    logic c31;
  } gen_step_t;

endpackage

// File: rtl/tia_audio_lfsr.sv
// Fibonacci LFSR: shifts left, feeds back q[WIDTH-1]^q[TAP]; resets to and recovers from zero into all-ones.
module tia_audio_lfsr #(
  parameter int WIDTH = 4,
  parameter int TAP   = 2
) (
  input  logic             phi2,
  input  logic             reset_bar,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  assign q_next = {q[WIDTH-2:0], q[WIDTH-1] ^ q[TAP]};

  // A zero state would lock the register, so it is replaced by all-ones on the same step.
  always_ff @(posedge phi2 or negedge reset_bar) begin
    if (!reset_bar) begin
      q <= '1;
    end else if (step) begin
      q <= (q_next == '0) ? '1 : q_next;
    end
  end

endmodule

// File: rtl/tia_audio_channel.sv
// One TIA audio channel: AUDC/AUDF/AUDV latches, AUDF divider, waveform generators, volume output.
// Optional debug readback ports audc_q/audf_q/audv_q are enabled by TIA_AUDIO_READBACK_EN.
module tia_audio_channel
  import tia_audio_pkg::*;
#(
  parameter int FREQ_W = 5,
  parameter int VOL_W  = 4
) (
  input  logic              phi2,
  input  logic              reset_bar,
  input  logic [7:0]        d,
  input  logic              auc,
  input  logic              auf,
  input  logic              auv,
  input  logic              aud_ce,
`ifdef TIA_AUDIO_READBACK_EN
  output logic [3:0]        audc_q,
  output logic [FREQ_W-1:0] audf_q,
  output logic [VOL_W-1:0]  audv_q,
`endif
  output logic [VOL_W-1:0]  aud_out
);

  logic [3:0]        audc;
  logic [FREQ_W-1:0] audf;
  logic [VOL_W-1:0]  audv;
  logic [FREQ_W-1:0] div;
  logic              tick;

  logic [P4_W-1:0]   p4;
  logic [P5_W-1:0]   p5;
  logic [P9_W-1:0]   p9;
  logic              t2;
  logic [1:0]        c3;
  logic [2:0]        c6;
  logic [4:0]        c31;

  gen_step_t         step;
  logic              w;

  logic              d_unused;
  assign d_unused = ^d[7:FREQ_W];

  always_ff @(posedge phi2 or negedge reset_bar) begin
    if (!reset_bar) begin
      audc <= '0;
      audf <= '0;
      audv <= '0;
    end else begin
      if (auc) audc <= d[3:0];
      if (auf) audf <= d[FREQ_W-1:0];
      if (auv) audv <= d[VOL_W-1:0];
    end
  end

  // >= rather than == so a smaller AUDF written mid-count ticks at once instead of wrapping.
  assign tick = aud_ce & (div >= audf);

  always_ff @(posedge phi2 or negedge reset_bar) begin
    if (!reset_bar) begin
      div <= '0;
    end else if (aud_ce) begin
      div <= tick ? '0 : div + 1'b1;
    end
  end

  always_comb begin
    step = '0;
    w    = 1'b1;
    case (audc)
      AUDC_P4: begin
        w       = p4[P4_W-1];
        step.p4 = tick;
      end
      AUDC_P5_P4: begin
        w       = p4[P4_W-1];
        step.p5 = tick;
        step.p4 = tick & p5[P5_W-1];
      end
      AUDC_P5, AUDC_P5_A, AUDC_P5_B: begin
        w       = p5[P5_W-1];
        step.p5 = tick;
      end
      AUDC_DIV2_A, AUDC_DIV2_B: begin
        w       = t2;
        step.t2 = tick;
      end
      AUDC_DIV31_A, AUDC_DIV31_B: begin
        w        = (c31 < C31_DUTY);
        step.c31 = tick;
      end
      AUDC_P9: begin
        w       = p9[P9_W-1];
        step.p9 = tick;
      end
      AUDC_DIV6_A, AUDC_DIV6_B: begin
        w       = (c6 < C6_DUTY);
        step.c6 = tick;
      end
      AUDC_DIV93: begin
        w        = (c31 < C31_DUTY);
        step.c3  = tick;
        step.c31 = tick & (c3 == C3_LAST);
      end
      AUDC_P5_DIV6: begin
        w       = (c6 < C6_DUTY);
        step.p5 = tick;
        step.c6 = tick & p5[P5_W-1];
      end
      default: begin
        w = 1'b1;
      end
    endcase
  end

  tia_audio_lfsr #(.WIDTH(P4_W), .TAP(P4_TAP)) u_p4 (
    .phi2(phi2), .reset_bar(reset_bar), .step(step.p4), .q(p4)
  );
  tia_audio_lfsr #(.WIDTH(P5_W), .TAP(P5_TAP)) u_p5 (
    .phi2(phi2), .reset_bar(reset_bar), .step(step.p5), .q(p5)
  );
  tia_audio_lfsr #(.WIDTH(P9_W), .TAP(P9_TAP)) u_p9 (
    .phi2(phi2), .reset_bar(reset_bar), .step(step.p9), .q(p9)
  );

  always_ff @(posedge phi2 or negedge reset_bar) begin
    if (!reset_bar) begin
      t2  <= 1'b0;
      c3  <= '0;
      c6  <= '0;
      c31 <= '0;
    end else begin
      if (step.t2)  t2  <= ~t2;
      if (step.c3)  c3  <= (c3 == C3_LAST) ? '0 : c3 + 2'd1;
      if (step.c6)  c6  <= (c6 == C6_LAST) ? '0 : c6 + 3'd1;
      if (step.c31) c31 <= (c31 == C31_LAST) ? '0 : c31 + 5'd1;
    end
  end

  always_ff @(posedge phi2 or negedge reset_bar) begin
    if (!reset_bar) begin
      aud_out <= '0;
    end else begin
      aud_out <= w ? audv : '0;
    end
  end

`ifdef TIA_AUDIO_READBACK_EN
  assign audc_q = audc;
  assign audf_q = audf;
  assign audv_q = audv;
`endif

endmodule

// File: tb/tb_tia_audio_channel.sv
// Self-checking bench for tia_audio_channel: vector table, hand sequences, random run against a model.
module tb_tia_audio_channel;

  logic       phi2;
  logic       reset_bar;
  logic [7:0] d;
  logic       auc, auf, auv, aud_ce;
  logic [3:0] aud_out;
`ifdef TIA_AUDIO_READBACK_EN
  logic [3:0] audc_q;
  logic [4:0] audf_q;
  logic [3:0] audv_q;
`endif

  tia_audio_channel dut (
    .phi2(phi2),
    .reset_bar(reset_bar),
    .d(d),
    .auc(auc),
    .auf(auf),
    .auv(auv),
    .aud_ce(aud_ce),
`ifdef TIA_AUDIO_READBACK_EN
    .audc_q(audc_q),
    .audf_q(audf_q),
    .audv_q(audv_q),
`endif
    .aud_out(aud_out)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: registers and generators as plain integers.
  int m_audc, m_audf, m_audv, m_div, m_out;
  int m_p4, m_p5, m_p9, m_t2, m_c3, m_c6, m_c31;

  task automatic model_reset();
    m_audc = 0; m_audf = 0; m_audv = 0; m_div = 0; m_out = 0;
    m_p4 = 15; m_p5 = 31; m_p9 = 511;
    m_t2 = 0; m_c3 = 0; m_c6 = 0; m_c31 = 0;
  endtask

  function automatic int lfsr(int v, int wd, int tap);
    int n;
    n = ((v << 1) & ((1 << wd) - 1)) | (((v >> (wd - 1)) ^ (v >> tap)) & 1);
    if (n == 0) n = (1 << wd) - 1;
    return n;
  endfunction

  function automatic int model_w();
    case (m_audc)
      1, 2:        return (m_p4 >> 3) & 1;
      3, 7, 9:     return (m_p5 >> 4) & 1;
      4, 5:        return m_t2;
      6, 10, 14:   return (m_c31 < 18) ? 1 : 0;
      8:           return (m_p9 >> 8) & 1;
      12, 13, 15:  return (m_c6 < 3) ? 1 : 0;
      default:     return 1;
    endcase
  endfunction

  task automatic model_edge(input logic [7:0] dd, input logic c, input logic f,
                            input logic v, input logic ce);
    int wv, g;
    bit tk;
    wv = model_w();
    g  = (m_p5 >> 4) & 1;
    tk = ce && (m_div >= m_audf);
    if (ce) m_div = tk ? 0 : m_div + 1;
    if (tk) begin
      case (m_audc)
        1:        m_p4 = lfsr(m_p4, 4, 2);
        2: begin
          m_p5 = lfsr(m_p5, 5, 2);
          if (g != 0) m_p4 = lfsr(m_p4, 4, 2);
        end
        3, 7, 9:  m_p5 = lfsr(m_p5, 5, 2);
        4, 5:     m_t2 = 1 - m_t2;
        6, 10:    m_c31 = (m_c31 + 1) % 31;
        8:        m_p9 = lfsr(m_p9, 9, 4);
        12, 13:   m_c6 = (m_c6 + 1) % 6;
        14: begin
          if (m_c3 == 2) m_c31 = (m_c31 + 1) % 31;
          m_c3 = (m_c3 + 1) % 3;
        end
        15: begin
          m_p5 = lfsr(m_p5, 5, 2);
          if (g != 0) m_c6 = (m_c6 + 1) % 6;
        end
        default: ;
      endcase
    end
    m_out = (wv != 0) ? m_audv : 0;
    if (c) m_audc = int'(dd) & 15;
    if (f) m_audf = int'(dd) & 31;
    if (v) m_audv = int'(dd) & 15;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic cycle(input logic [7:0] dd, input logic c, input logic f,
                       input logic v, input logic ce);
    d = dd; auc = c; auf = f; auv = v; aud_ce = ce;
    @(posedge phi2);
    model_edge(dd, c, f, v, ce);
    @(negedge phi2);
    d = 8'h00; auc = 1'b0; auf = 1'b0; auv = 1'b0; aud_ce = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       auc, auf, auv, ce;
    int         exp;
  } vec_t;

  vec_t tbl[32];

  initial begin
    int found;
    logic [7:0] rd;
    logic rc, rf, rv, rce;

    // Latch, divider (audf=3 on t2), audf shrink mid-count, and write coincident with aud_ce.
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{8'hA7, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7};
    tbl[3]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 7};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[7]  = '{8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[17] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[19] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[20] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[21] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[22] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[23] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[24] = '{8'h05, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[25] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[26] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[27] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[28] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[29] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[30] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    tbl[31] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    reset_bar = 1'b0;
    d = 8'h00; auc = 1'b0; auf = 1'b0; auv = 1'b0; aud_ce = 1'b0;
    model_reset();
    repeat (2) @(negedge phi2);
    check("reset_out", int'(aud_out), 0);
    reset_bar = 1'b1;
    @(negedge phi2);

    for (int i = 0; i < 32; i++) begin
      cycle(tbl[i].d, tbl[i].auc, tbl[i].auf, tbl[i].auv, tbl[i].ce);
      check($sformatf("vec%0d", i), int'(aud_out), tbl[i].exp);
    end

    // Poly4 from its reset seed, audf=0, audv=1.
    cycle(8'h01, 1'b1, 1'b0, 1'b0, 1'b0); check("p4_wr_c", int'(aud_out), m_out);
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0); check("p4_wr_f", int'(aud_out), m_out);
    cycle(8'h01, 1'b0, 1'b0, 1'b1, 1'b0); check("p4_wr_v", int'(aud_out), m_out);
    for (int k = 0; k < 30; k++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("p4_%0d", k), int'(aud_out), m_out);
    end

    // Div31: 18 high / 13 low per 31 ticks, then mode 14 stretches each count by 3.
    cycle(8'h06, 1'b1, 1'b0, 1'b0, 1'b0); check("d31_wr", int'(aud_out), m_out);
    for (int k = 0; k < 62; k++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("d31_%0d", k), int'(aud_out), ((k % 31) < 18) ? 1 : 0);
    end
    cycle(8'h0E, 1'b1, 1'b0, 1'b0, 1'b0); check("d93_wr", int'(aud_out), m_out);
    for (int k = 0; k < 186; k++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("d93_%0d", k), int'(aud_out), (((k / 3) % 31) < 18) ? 1 : 0);
    end

    // Random strobes, data and clock enables against the model.
    for (int k = 0; k < 400; k++) begin
      rd  = 8'($urandom);
      rc  = ($urandom_range(0, 7) == 0);
      rf  = ($urandom_range(0, 11) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rce = ($urandom_range(0, 1) == 1);
      cycle(rd, rc, rf, rv, rce);
      check($sformatf("rnd_%0d", k), int'(aud_out), m_out);
`ifdef TIA_AUDIO_READBACK_EN
      if (k % 50 == 0) begin
        check("rb_audc", int'(audc_q), m_audc);
        check("rb_audf", int'(audf_q), m_audf);
        check("rb_audv", int'(audv_q), m_audv);
      end
`endif
    end

    // Async reset between edges while mode 8 is running with a non-zero level.
    cycle(8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 64 && found == 0; k++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      if (m_out != 0) found = 1;
    end
    check("pre_reset_nonzero", found, 1);
    check("pre_reset_level", int'(aud_out), m_out);
    #2 reset_bar = 1'b0;
    #1 check("async_reset_out", int'(aud_out), 0);
    model_reset();
    @(negedge phi2);
    reset_bar = 1'b1;
    @(negedge phi2);

    // p9 must restart from all-ones: mode 8 sequence checked from the seed.
    cycle(8'h08, 1'b1, 1'b0, 1'b0, 1'b0); check("p9_wr_c", int'(aud_out), m_out);
    cycle(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0); check("p9_wr_v", int'(aud_out), m_out);
    for (int k = 0; k < 40; k++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("p9_%0d", k), int'(aud_out), m_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
